// File: rtl/usadd_n_pkg.sv
// Shared sizing helpers and mode encodings for the unary adder family.
package usadd_pkg;

    localparam logic MODE_SCALED = 1'b0;
    localparam logic MODE_SAT    = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Holds acc + popcount, which peaks at 2*NINPUT-1.
    function automatic int acc_w(input int ninput);
        return clog2(2 * ninput);
    endfunction

    function automatic int cnt_w(input int winlog);
        return winlog + 1;
    endfunction

endpackage

// File: rtl/usadd_n_if.sv
// Stream-side bundle of the N-input unary adder: qualifiers, inputs and results.
interface usadd_n_if #(
    parameter int NINPUT = 4,
    parameter int WINLOG = 8
);
    logic              en;
    logic              clr;
    logic              mode;
    logic [NINPUT-1:0] a;
    logic              c;
    logic [WINLOG:0]   ones;
    logic              done;

    modport master (output en, clr, mode, a, input  c, ones, done);
    modport slave  (input  en, clr, mode, a, output c, ones, done);
endinterface

// File: rtl/usadd_n_popcount_n.sv
// Combinational ones-counter over NINPUT bits; reusable by other reduction blocks.
module popcount_n
    import usadd_pkg::*;
#(
    parameter int NINPUT = 4,
    localparam int PW    = clog2(NINPUT + 1)
) (
    input  logic [NINPUT-1:0] a,
    output logic [PW-1:0]     cnt
);
    // Written as a sum; synthesis rebalances it into an adder tree.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NINPUT; i++)
            cnt = cnt + PW'(a[i]);
    end
endmodule

// File: rtl/usadd_n.sv
// N-input scaled/saturating unary adder with a windowed ones-counter.
// Build option: USADD_N_ROUND_EN presets acc to floor(NINPUT/2) for rounding.
module usadd_n
    import usadd_pkg::*;
#(
    parameter int NINPUT = 4,
    parameter int WINLOG = 8
) (
    input logic    iClk,
    input logic    iRstN,
    usadd_n_if.slave bus
);
    localparam int AW = acc_w(NINPUT);
    localparam int PW = clog2(NINPUT + 1);
    localparam int CW = cnt_w(WINLOG);

`ifdef USADD_N_ROUND_EN
    localparam logic [AW-1:0] ACC_INIT = AW'(NINPUT / 2);
`else
    localparam logic [AW-1:0] ACC_INIT = '0;
`endif

    logic [PW-1:0]     p;
    logic [AW-1:0]     acc, s, d, r, acc_nxt;
    logic              c_nxt, wrap;
    logic [WINLOG-1:0] win_cnt;
    logic [CW-1:0]     ones_run, run_nxt;
    logic              c_q, done_q;
    logic [CW-1:0]     ones_q;

    popcount_n #(.NINPUT(NINPUT)) u_pop (.a(bus.a), .cnt(p));

    always_comb begin
        s       = acc + AW'(p);
        d       = (bus.mode == MODE_SAT) ? AW'(1) : AW'(NINPUT);
        c_nxt   = (s >= d);
        r       = c_nxt ? (s - d) : s;
        // Scaled mode keeps r below NINPUT on its own; saturating mode drops the excess.
        acc_nxt = (bus.mode == MODE_SAT && r > AW'(NINPUT - 1)) ? AW'(NINPUT - 1) : r;
        wrap    = &win_cnt;
        run_nxt = ones_run + CW'(c_nxt);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            acc      <= ACC_INIT;
            c_q      <= 1'b0;
            win_cnt  <= '0;
            ones_run <= '0;
            ones_q   <= '0;
            done_q   <= 1'b0;
        end else if (bus.clr) begin
            acc      <= ACC_INIT;
            c_q      <= 1'b0;
            win_cnt  <= '0;
            ones_run <= '0;
            done_q   <= 1'b0;
        end else if (bus.en) begin
            acc     <= acc_nxt;
            c_q     <= c_nxt;
            win_cnt <= win_cnt + 1'b1;
            if (wrap) begin
                ones_q   <= run_nxt;
                ones_run <= '0;
                done_q   <= 1'b1;
            end else begin
                ones_run <= run_nxt;
                done_q   <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bus.c    = c_q;
    assign bus.ones = ones_q;
    assign bus.done = done_q;
endmodule
